// File: rtl/lanes_deserializer.sv
// Two-lane receive deserializer: rebuilds parallel blocks from the lane bit
// streams and aligns on Gen2/Gen3 sync headers before qualifying output.
module lanes_deserializer #(
  parameter int WIDTH      = 132,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_deser,
  input  logic [1:0]       gen_speed,
  input  logic             lane_0_rx_ser,
  input  logic             lane_1_rx_ser,
  output logic [WIDTH-1:0] lane_0_rx_parallel,
  output logic [WIDTH-1:0] lane_1_rx_parallel,
  output logic             rx_valid,
  output logic             block_lock,
  output logic             descr_rst,
  output logic             enable_descr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  function automatic logic [CW-1:0] blk_len(input logic [1:0] g);
    case (g)
      2'b01:   return CW'(132);
      2'b10:   return CW'(66);
      default: return CW'(8);
    endcase
  endfunction

  function automatic logic hdr_ok(input logic [3:0] h, input logic gen3);
    logic v;
    v = h[1] ^ h[0];
    if (gen3) v = v && (h[3:2] == h[1:0]);
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic             slip_q, slip_d;
  logic [1:0]       gen_q;

  logic [CW-1:0]    cnt_p0;
  logic [WIDTH-1:0] sr0_p0, sr1_p0;
  logic [WIDTH-1:0] word0_p1, word1_p1;
  logic             vld_p1, dr_p1, edescr_p1;

  logic             gen4, gen3, restart, take, bnd, hdr_good;
  logic [CW-1:0]    n;
  logic [WIDTH-1:0] mask, nxt0, nxt1;

  // Stage p0: next shift-register contents and boundary decode
  always_comb begin
    gen4    = (gen_speed == 2'b00) || (gen_speed == 2'b11);
    gen3    = (gen_speed == 2'b01);
    n       = blk_len(gen_speed);
    mask    = {WIDTH{1'b1}} >> (CW'(WIDTH) - n);
    restart = !enable_deser || (gen_speed != gen_q);
    take    = !restart && !slip_q;
    bnd     = take && (cnt_p0 == n - CW'(1));
    if (gen4) begin
      nxt0 = {sr0_p0[WIDTH-2:0], lane_0_rx_ser} & mask;
      nxt1 = {sr1_p0[WIDTH-2:0], lane_1_rx_ser} & mask;
    end else begin
      nxt0 = ((sr0_p0 >> 1) | (WIDTH'(lane_0_rx_ser) << (n - CW'(1)))) & mask;
      nxt1 = ((sr1_p0 >> 1) | (WIDTH'(lane_1_rx_ser) << (n - CW'(1)))) & mask;
    end
    hdr_good = hdr_ok(nxt0[3:0], gen3) && hdr_ok(nxt1[3:0], gen3);
  end

  // Alignment FSM: a failed header while hunting drops the next bit (slip)
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    slip_d  = 1'b0;
    if (restart) begin
      state_d = HUNT;
      good_d  = '0;
      bad_d   = '0;
    end else if (bnd) begin
      if (gen4) begin
        state_d = LOCKED;
        good_d  = '0;
        bad_d   = '0;
      end else begin
        case (state_q)
          HUNT: begin
            if (hdr_good) begin
              if (good_q == GW'(LOCK_CNT - 1)) begin
                state_d = LOCKED;
                good_d  = '0;
                bad_d   = '0;
              end else begin
                good_d = good_q + GW'(1);
              end
            end else begin
              good_d = '0;
              slip_d = 1'b1;
            end
          end
          LOCKED: begin
            if (hdr_good) begin
              bad_d = '0;
            end else if (bad_q == BW'(UNLOCK_CNT - 1)) begin
              state_d = HUNT;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + BW'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      good_q  <= '0;
      bad_q   <= '0;
      slip_q  <= 1'b0;
      gen_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      slip_q  <= slip_d;
      gen_q   <= gen_speed;
    end
  end

  // Stage p1: word capture and one-cycle strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0    <= '0;
      sr0_p0    <= '0;
      sr1_p0    <= '0;
      word0_p1  <= '0;
      word1_p1  <= '0;
      vld_p1    <= 1'b0;
      dr_p1     <= 1'b0;
      edescr_p1 <= 1'b0;
    end else begin
      vld_p1    <= 1'b0;
      dr_p1     <= 1'b0;
      edescr_p1 <= !restart && (state_q == LOCKED);
      if (restart) begin
        cnt_p0 <= '0;
        sr0_p0 <= '0;
        sr1_p0 <= '0;
      end else if (take) begin
        sr0_p0 <= nxt0;
        sr1_p0 <= nxt1;
        if (bnd) begin
          cnt_p0   <= '0;
          word0_p1 <= nxt0;
          word1_p1 <= nxt1;
          dr_p1    <= 1'b1;
          vld_p1   <= (state_q == LOCKED);
        end else begin
          cnt_p0 <= cnt_p0 + CW'(1);
        end
      end
    end
  end

  assign lane_0_rx_parallel = word0_p1;
  assign lane_1_rx_parallel = word1_p1;
  assign rx_valid           = vld_p1;
  assign descr_rst          = dr_p1;
  assign enable_descr       = edescr_p1;
  assign block_lock         = (state_q == LOCKED);

endmodule
